// File: rtl/rs232_fifo_client_if.sv
// rs232_fifo_client_if: UART character handshake plus CPU-side RX/TX FIFO ports
// master: the FIFO client (drives readRX/writeTX/TXchar and the FIFO status outputs)
// slave:  the UART plus CPU side (drives RXchar/charReady/TXempty, rxPop, txData/txPush)
interface rs232_fifo_client_if #(
    parameter int RXLOG = 4,
    parameter int TXLOG = 4
);
    logic             readRX;
    logic [7:0]       RXchar;
    logic             charReady;
    logic             writeTX;
    logic [7:0]       TXchar;
    logic             TXempty;
    logic [7:0]       rxData;
    logic             rxValid;
    logic             rxPop;
    logic [RXLOG:0]   rxCount;
    logic [7:0]       txData;
    logic             txPush;
    logic             txFull;
    logic [TXLOG:0]   txCount;
    logic             rxBlocked;
    modport master (
        output readRX, writeTX, TXchar, rxData, rxValid, rxCount, txFull, txCount, rxBlocked,
        input  RXchar, charReady, TXempty, rxPop, txData, txPush
    );
    modport slave (
        input  readRX, writeTX, TXchar, rxData, rxValid, rxCount, txFull, txCount, rxBlocked,
        output RXchar, charReady, TXempty, rxPop, txData, txPush
    );
endinterface

// File: rtl/rs232_fifo_client.sv
// rs232_fifo_client: drains UART RX characters into a FIFO and feeds a TX FIFO to the UART
// clock/reset: single clock, synchronous active-high reset
// bus (master): UART handshake (readRX/RXchar/charReady, writeTX/TXchar/TXempty)
//               and FWFT FIFO ports (rxData/rxValid/rxPop/rxCount, txData/txPush/txFull/txCount, rxBlocked)
module rs232_fifo_client #(
    parameter int RXLOG = 4,
    parameter int TXLOG = 4
) (
    input logic clock,
    input logic reset,
    rs232_fifo_client_if.master bus
);
    localparam logic [RXLOG:0] RX_DEPTH = (RXLOG+1)'(2**RXLOG);
    localparam logic [TXLOG:0] TX_DEPTH = (TXLOG+1)'(2**TXLOG);
    typedef enum logic {RX_IDLE, RX_SETTLE} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_ISSUE, TX_BUSY} tx_state_t;
    logic [7:0]       r_rx_mem [2**RXLOG];
    logic [RXLOG-1:0] r_rx_wp, r_rx_rp;
    logic [RXLOG:0]   r_rx_cnt;
    rx_state_t        r_rx_state;
    logic             r_rx_blocked;
    logic [7:0]       r_tx_mem [2**TXLOG];
    logic [TXLOG-1:0] r_tx_wp, r_tx_rp;
    logic [TXLOG:0]   r_tx_cnt;
    tx_state_t        r_tx_state;
    logic             r_write_tx;
    logic [7:0]       r_tx_char;
    logic             r_tx_wait;
    logic w_rx_full, w_rx_push, w_rx_pop, w_tx_full, w_tx_push, w_tx_pop;
    // Fullness comes from the occupancy register, so a same-cycle pop never frees room early.
    assign w_rx_full = r_rx_cnt == RX_DEPTH;
    assign w_rx_push = r_rx_state == RX_IDLE && bus.charReady && !w_rx_full;
    assign w_rx_pop  = bus.rxPop && r_rx_cnt != '0;
    assign w_tx_full = r_tx_cnt == TX_DEPTH;
    assign w_tx_push = bus.txPush && !w_tx_full;
    assign w_tx_pop  = r_tx_state == TX_ISSUE;
    always_ff @(posedge clock) if (w_rx_push) r_rx_mem[r_rx_wp] <= bus.RXchar;
    always_ff @(posedge clock) if (w_tx_push) r_tx_mem[r_tx_wp] <= bus.txData;
    // readRX is the push strobe itself; SETTLE skips the cycle in which charReady is still stale.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_state   <= RX_IDLE;
            r_rx_wp      <= '0;
            r_rx_rp      <= '0;
            r_rx_cnt     <= '0;
            r_rx_blocked <= 1'b0;
        end else begin
            r_rx_state <= w_rx_push ? RX_SETTLE : RX_IDLE;
            r_rx_wp    <= r_rx_wp + (RXLOG)'(w_rx_push);
            r_rx_rp    <= r_rx_rp + (RXLOG)'(w_rx_pop);
            r_rx_cnt   <= r_rx_cnt + (RXLOG+1)'(w_rx_push) - (RXLOG+1)'(w_rx_pop);
            if (r_rx_state == RX_IDLE && bus.charReady && w_rx_full) r_rx_blocked <= 1'b1;
        end
    end
    // BUSY ignores TXempty for its first cycle, while the UART is still loading its counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_wp    <= '0;
            r_tx_rp    <= '0;
            r_tx_cnt   <= '0;
            r_write_tx <= 1'b0;
            r_tx_char  <= '0;
            r_tx_wait  <= 1'b0;
        end else begin
            r_tx_wp  <= r_tx_wp + (TXLOG)'(w_tx_push);
            r_tx_rp  <= r_tx_rp + (TXLOG)'(w_tx_pop);
            r_tx_cnt <= r_tx_cnt + (TXLOG+1)'(w_tx_push) - (TXLOG+1)'(w_tx_pop);
            case (r_tx_state)
                TX_IDLE: if (r_tx_cnt != '0 && bus.TXempty) begin
                    r_tx_state <= TX_ISSUE;
                    r_write_tx <= 1'b1;
                    r_tx_char  <= r_tx_mem[r_tx_rp];
                end
                TX_ISSUE: begin
                    r_tx_state <= TX_BUSY;
                    r_write_tx <= 1'b0;
                    r_tx_wait  <= 1'b1;
                end
                TX_BUSY: begin
                    r_tx_wait <= 1'b0;
                    if (!r_tx_wait && bus.TXempty) r_tx_state <= TX_IDLE;
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end
    assign bus.readRX    = w_rx_push;
    assign bus.writeTX   = r_write_tx;
    assign bus.TXchar    = r_tx_char;
    assign bus.rxData    = r_rx_mem[r_rx_rp];
    assign bus.rxValid   = r_rx_cnt != '0;
    assign bus.rxCount   = r_rx_cnt;
    assign bus.txFull    = w_tx_full;
    assign bus.txCount   = r_tx_cnt;
    assign bus.rxBlocked = r_rx_blocked;
endmodule

// File: tb/tb_rs232_fifo_client.sv
// tb_rs232_fifo_client: UART model plus scoreboard bench for rs232_fifo_client
module tb_rs232_fifo_client;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;
    rs232_fifo_client_if bus ();
    rs232_fifo_client dut (.clock(clock), .reset(reset), .bus(bus));
    int n_tests = 0;
    int n_fail = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;
    int busy = 0;
    bit tx_off = 1'b0;
    logic prev_wr = 1'b0;
    logic [7:0] uart_q[$];
    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask
    task automatic uart_send(input logic [7:0] c);
        uart_q.push_back(c);
        rx_exp.push_back(c);
    endtask
    task automatic wait_wr(input string name, input int lim);
        int k = 0;
        @(negedge clock);
        while (!bus.writeTX && k < lim) begin
            @(negedge clock);
            k++;
        end
        chk(name, bus.writeTX, 1);
    endtask
    // UART receive side: present one character, drop charReady one cycle after readRX
    initial begin
        logic rd;
        bus.charReady = 1'b0;
        bus.RXchar = 8'h00;
        forever begin
            @(negedge clock);
            #3;
            rd = bus.readRX;
            if (rd) chk("readRX_needs_charReady", bus.charReady, 1);
            @(posedge clock);
            #1;
            if (rd) begin
                bus.charReady = 1'b0;
                rd_pulses++;
            end else if (!bus.charReady && uart_q.size() > 0) begin
                bus.RXchar = uart_q.pop_front();
                bus.charReady = 1'b1;
            end
        end
    end
    // UART transmit side: 12 bit times of 2 cycles each after every writeTX
    initial begin
        logic wr;
        bus.TXempty = 1'b1;
        forever begin
            @(negedge clock);
            #3;
            wr = bus.writeTX;
            @(posedge clock);
            #1;
            if (wr) begin
                busy = 24;
                wr_pulses++;
            end else if (busy > 0) busy--;
            bus.TXempty = busy == 0 && !tx_off;
        end
    end
    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clock);
            #3;
            if (bus.rxValid && bus.rxPop) begin
                if (rx_exp.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got 0x%0h, expected no data", bus.rxData);
                end else chk("rx_data_order", bus.rxData, rx_exp.pop_front());
            end
            if (bus.writeTX) begin
                if (tx_exp.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got writeTX with 0x%0h, expected none", bus.TXchar);
                end else chk("tx_char", bus.TXchar, tx_exp.pop_front());
                chk("tx_not_back_to_back", prev_wr, 0);
                chk("tx_only_when_idle", bus.TXempty, 1);
            end
            prev_wr = bus.writeTX;
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end
    initial begin
        int k;
        bus.rxPop = 1'b0;
        bus.txData = 8'h00;
        bus.txPush = 1'b0;
        // Reset values
        step(3);
        @(negedge clock);
        chk("rst_readRX", bus.readRX, 0);
        chk("rst_writeTX", bus.writeTX, 0);
        chk("rst_TXchar", bus.TXchar, 0);
        chk("rst_rxValid", bus.rxValid, 0);
        chk("rst_rxCount", bus.rxCount, 0);
        chk("rst_txCount", bus.txCount, 0);
        chk("rst_txFull", bus.txFull, 0);
        chk("rst_rxBlocked", bus.rxBlocked, 0);
        step(1);
        reset = 1'b0;
        // 1: single receive
        uart_send(8'h41);
        step(1);
        @(negedge clock);
        chk("t1_readRX", bus.readRX, 1);
        step(2);
        @(negedge clock);
        chk("t1_rxValid", bus.rxValid, 1);
        chk("t1_rxData", bus.rxData, 8'h41);
        chk("t1_rxCount", bus.rxCount, 1);
        step(4);
        chk("t1_one_readRX", rd_pulses, 1);
        bus.rxPop = 1'b1;
        step(1);
        bus.rxPop = 1'b0;
        @(negedge clock);
        chk("t1_rxCount_popped", bus.rxCount, 0);
        // 2: two transmits back-to-back
        step(1);
        bus.txPush = 1'b1;
        bus.txData = 8'h48;
        tx_exp.push_back(8'h48);
        step(1);
        bus.txData = 8'h69;
        tx_exp.push_back(8'h69);
        step(1);
        bus.txPush = 1'b0;
        @(negedge clock);
        chk("t2_writeTX_latency", bus.writeTX, 1);
        chk("t2_txCount2", bus.txCount, 2);
        step(1);
        @(negedge clock);
        chk("t2_txCount1", bus.txCount, 1);
        chk("t2_writeTX_low", bus.writeTX, 0);
        wait_wr("t2_second_writeTX", 80);
        step(1);
        @(negedge clock);
        chk("t2_txCount0", bus.txCount, 0);
        chk("t2_wr_pulses", wr_pulses, 2);
        step(30);
        // 3: RX FIFO full, 17th character blocked
        for (int i = 0; i < 17; i++) uart_send(8'h60 + 8'(i));
        step(45);
        @(negedge clock);
        chk("t3_rxCount_full", bus.rxCount, 16);
        chk("t3_rxBlocked", bus.rxBlocked, 1);
        chk("t3_no_readRX", bus.readRX, 0);
        chk("t3_rd_pulses", rd_pulses, 17);
        step(1);
        bus.rxPop = 1'b1;
        step(1);
        bus.rxPop = 1'b0;
        step(4);
        @(negedge clock);
        chk("t3_rxCount_refill", bus.rxCount, 16);
        chk("t3_rd_pulses_after_pop", rd_pulses, 18);
        step(1);
        bus.rxPop = 1'b1;
        step(16);
        bus.rxPop = 1'b0;
        @(negedge clock);
        chk("t3_rxCount_drained", bus.rxCount, 0);
        chk("t3_rxValid_drained", bus.rxValid, 0);
        chk("t3_rxBlocked_sticky", bus.rxBlocked, 1);
        // 5: simultaneous push and pop at rxCount=3
        for (int i = 0; i < 3; i++) uart_send(8'h31 + 8'(i));
        step(10);
        @(negedge clock);
        chk("t5_rxCount3", bus.rxCount, 3);
        uart_send(8'h34);
        k = 0;
        @(negedge clock);
        while (!bus.readRX && k < 10) begin
            @(negedge clock);
            k++;
        end
        chk("t5_readRX_seen", bus.readRX, 1);
        #1;
        bus.rxPop = 1'b1;
        @(posedge clock);
        #2;
        bus.rxPop = 1'b0;
        @(negedge clock);
        chk("t5_rxCount_same", bus.rxCount, 3);
        step(1);
        bus.rxPop = 1'b1;
        step(3);
        bus.rxPop = 1'b0;
        @(negedge clock);
        chk("t5_rxCount_drained", bus.rxCount, 0);
        // 4: TX FIFO full, refused pushes
        tx_off = 1'b1;
        step(2);
        bus.txPush = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.txData = 8'hA0 + 8'(i);
            tx_exp.push_back(8'hA0 + 8'(i));
            step(1);
        end
        bus.txData = 8'h55;
        step(1);
        @(negedge clock);
        chk("t4_txFull", bus.txFull, 1);
        chk("t4_txCount16", bus.txCount, 16);
        tx_off = 1'b0;
        wait_wr("t4_issue_seen", 10);
        @(posedge clock);
        #2;
        bus.txPush = 1'b0;
        @(negedge clock);
        chk("t4_txCount15", bus.txCount, 15);
        chk("t4_txFull_clear", bus.txFull, 0);
        k = 0;
        while (bus.txCount != 0 && k < 1000) begin
            @(negedge clock);
            k++;
        end
        chk("t4_txCount_drained", bus.txCount, 0);
        k = 0;
        while (!bus.TXempty && k < 60) begin
            @(negedge clock);
            k++;
        end
        chk("t4_uart_idle", bus.TXempty, 1);
        chk("t4_wr_pulses", wr_pulses, 18);
        // 6: reset while BUSY with 5 queued
        step(1);
        bus.txPush = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.txData = 8'hC0 + 8'(i);
            tx_exp.push_back(8'hC0 + 8'(i));
            step(1);
        end
        bus.txPush = 1'b0;
        step(4);
        @(negedge clock);
        chk("t6_txCount5", bus.txCount, 5);
        step(1);
        reset = 1'b1;
        tx_exp.delete();
        step(1);
        @(negedge clock);
        chk("t6_writeTX", bus.writeTX, 0);
        chk("t6_txCount", bus.txCount, 0);
        chk("t6_rxBlocked", bus.rxBlocked, 0);
        chk("t6_rxCount", bus.rxCount, 0);
        step(1);
        reset = 1'b0;
        step(60);
        chk("t6_no_stale_writeTX", wr_pulses, 19);
        chk("rx_scoreboard_empty", rx_exp.size(), 0);
        chk("tx_scoreboard_empty", tx_exp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
